// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter over NUM_REQ requesters; optional grant locking via RR_ARB_LOCK_EN.
// Latency: grant is registered one cycle after the deciding edge.
// Backpressure: en_i low freezes grant outputs and priority pointer.
module rr_arbiter_param #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] above_ptr;
    logic [NUM_REQ-1:0] req_masked;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   next_ptr;
    logic               win_vld;

    // Requests at or above ptr take precedence; if none, the lowest request wraps around.
    always_comb begin
        above_ptr  = '0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            above_ptr[i] = (IDX_W'(i) >= ptr);
        end
        req_masked = req_i & above_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_idx    = IDX_W'(i);
                win_onehot = '0;
                win_onehot[i] = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_masked[i]) begin
                win_idx    = IDX_W'(i);
                win_onehot = '0;
                win_onehot[i] = 1'b1;
            end
        end
        win_vld  = |req_i;
        next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end

`ifndef RR_ARB_LOCK_EN
    logic release_unused;
    assign release_unused = release_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_o     <= '0;
            gnt_idx_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i && win_vld) begin
                        state     <= GRANT;
                        gnt_o     <= win_onehot;
                        gnt_idx_o <= win_idx;
                        ptr       <= next_ptr;
                    end
                end
                GRANT: begin
                    if (en_i) begin
`ifdef RR_ARB_LOCK_EN
                        // Locked: only release or loss of the owner's request ends the grant.
                        if (release_i || !(|(req_i & gnt_o))) begin
                            state     <= IDLE;
                            gnt_o     <= '0;
                            gnt_idx_o <= '0;
                        end
`else
                        if (win_vld) begin
                            gnt_o     <= win_onehot;
                            gnt_idx_o <= win_idx;
                            ptr       <= next_ptr;
                        end else begin
                            state     <= IDLE;
                            gnt_o     <= '0;
                            gnt_idx_o <= '0;
                        end
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_o     <= '0;
                    gnt_idx_o <= '0;
                end
            endcase
        end
    end

    assign gnt_valid_o = |gnt_o;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed and random checks of rr_arbiter_param against a modulo-search reference model.
module tb_rr_arbiter_param;

    localparam int N = 5;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         en;
    logic         rel;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         gnt_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: granted index (-1 when idle) and priority start position.
    int m_idx = -1;
    int m_ptr = 0;

    rr_arbiter_param #(.NUM_REQ(N), .IDX_W(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .en_i        (en),
        .release_i   (rel),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] q, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (q[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] q, input logic e, input logic l);
        int w;
        if (r) begin
            m_idx = -1;
            m_ptr = 0;
        end else if (m_idx < 0) begin
            w = pick(q, m_ptr);
            if (e && w >= 0) begin
                m_idx = w;
                m_ptr = (w + 1) % N;
            end
        end else if (e) begin
`ifdef RR_ARB_LOCK_EN
            if (l || !q[m_idx]) m_idx = -1;
`else
            w = pick(q, m_ptr);
            if (w >= 0) begin
                m_idx = w;
                m_ptr = (w + 1) % N;
            end else begin
                m_idx = -1;
            end
`endif
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_gnt;
        logic         consistent;
        exp_gnt = (m_idx < 0) ? '0 : N'(1) << m_idx;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("gnt_idx", 32'(gnt_idx), (m_idx < 0) ? 32'd0 : 32'(m_idx));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_idx >= 0));
        consistent = (gnt == '0) ? (gnt_idx == '0) : (gnt == (N'(1) << gnt_idx));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("valid_is_or", 32'(gnt_valid == (|gnt)), 32'd1);
        chk("idx_matches_gnt", 32'(consistent), 32'd1);
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] q, input logic e, input logic l);
        rst = r;
        req = q;
        en  = e;
        rel = l;
        @(posedge clk);
        model_step(r, q, e, l);
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        en  = 1'b0;
        rel = 1'b0;

        cycle(1'b1, 5'b11111, 1'b1, 1'b1);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_valid", 32'(gnt_valid), 32'd0);

`ifdef RR_ARB_LOCK_EN
        begin
            logic [7:0] exp_v;
            int         exp_i [8];
            exp_v = 8'b01110111;
            exp_i = '{1, 1, 1, 0, 2, 2, 2, 0};
            for (int k = 1; k <= 8; k++) begin
                cycle(1'b0, 5'b00110, 1'b1, (k % 4) == 0);
                chk("lock_seq_valid", 32'(gnt_valid), 32'(exp_v[k-1]));
                chk("lock_seq_idx", 32'(gnt_idx), 32'(exp_i[k-1]));
            end
        end

        cycle(1'b1, 5'b00000, 1'b0, 1'b0);
        cycle(1'b0, 5'b01000, 1'b1, 1'b0);
        chk("lock_req3_idx", 32'(gnt_idx), 32'd3);
        cycle(1'b0, 5'b01001, 1'b1, 1'b0);
        chk("lock_req3_hold", 32'(gnt_idx), 32'd3);
        cycle(1'b0, 5'b00001, 1'b1, 1'b0);
        chk("lock_drop_bubble", 32'(gnt_valid), 32'd0);

        cycle(1'b1, 5'b00000, 1'b0, 1'b0);
        cycle(1'b0, 5'b00100, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, N'($urandom), 1'b0, 1'($urandom));
            chk("en_low_hold", 32'(gnt), 32'h04);
        end
        cycle(1'b0, 5'b00100, 1'b1, 1'b1);
        cycle(1'b0, 5'b11111, 1'b1, 1'b0);
        chk("ptr_after_hold", 32'(gnt_idx), 32'd3);
        cycle(1'b0, 5'b11111, 1'b1, 1'b1);
        cycle(1'b0, 5'b10000, 1'b1, 1'b0);
        chk("grant_idx4", 32'(gnt_idx), 32'd4);
`else
        begin
            int exp_i [5];
            exp_i = '{0, 2, 4, 0, 2};
            for (int k = 0; k < 5; k++) begin
                cycle(1'b0, 5'b10101, 1'b1, 1'b0);
                chk("rr_seq_idx", 32'(gnt_idx), 32'(exp_i[k]));
            end
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, N'($urandom), 1'b0, 1'($urandom));
            chk("en_low_hold", 32'(gnt), 32'h04);
        end
        cycle(1'b0, 5'b11111, 1'b1, 1'b0);
        chk("ptr_after_hold", 32'(gnt_idx), 32'd3);
        cycle(1'b0, 5'b11111, 1'b1, 1'b0);
        chk("grant_idx4", 32'(gnt_idx), 32'd4);
`endif

        cycle(1'b1, 5'b11111, 1'b1, 1'b1);
        chk("mid_grant_reset", 32'(gnt_valid), 32'd0);
        cycle(1'b0, 5'b11111, 1'b1, 1'b0);
        chk("post_reset_idx0", 32'(gnt_idx), 32'd0);
        chk("post_reset_valid", 32'(gnt_valid), 32'd1);

        // All requesters held: each must appear once per N grants.
        begin
            int seen [N];
            for (int j = 0; j < N; j++) seen[j] = 0;
            for (int k = 0; k < 2 * N; k++) begin
                cycle(1'b0, 5'b11111, 1'b1, 1'b1);
                if (gnt_valid) seen[gnt_idx]++;
            end
`ifndef RR_ARB_LOCK_EN
            for (int j = 0; j < N; j++) chk("rotation_fair", 32'(seen[j]), 32'd2);
`endif
        end

        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 49) == 0, N'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
